fp32_stream_accumulator: RTL and testbench
==========================================

// Module: fp32_stream_accumulator
// PURPOSE
//  Sequential front end for the combinational FP32 adder/subtractor. It accepts a framed
//  stream of FP32 operands over a valid/ready handshake. Each operand carries a per-beat
//  add/subtract flag. Operands are presented to the adder as registered (acc, operand)
//  pairs, and the adder's sum is written back into the accumulator. At end of frame the
//  block emits one FP32 result and the beat count. The adder sits outside this block and
//  connects through the add_* ports.
// PARAMETERS
//  CNT_W   8   width of the beat counter; the counter saturates at 2^CNT_W-1
// PORTS
//  clk         in   1      single clock; all state changes on its rising edge
//  rst_n       in   1      asynchronous active-low reset
//  flush       in   1      synchronous abort; returns to IDLE and discards the frame
//  in_data     in   32     FP32 operand
//  in_sub      in   1      1: subtract this operand (its sign is inverted before use)
//  in_last     in   1      final beat of the frame
//  in_valid    in   1      operand valid
//  in_ready    out  1      block can accept an operand
//  out_data    out  32     accumulated FP32 result
//  out_count   out  CNT_W  beats in the frame (saturating)
//  out_valid   out  1      result valid
//  out_ready   in   1      consumer accepts the result
//  add_a       out  32     adder operand A = acc register
//  add_b       out  32     adder operand B = opb register
//  add_result  in   32     combinational adder output
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE; acc, opb, cnt and last_q are all cleared to 0.
//   - Outputs: in_ready=0, out_valid=0, out_data=0, out_count=0, add_a=add_b=0.
//   - in_ready rises in the first cycle after rst_n deasserts.
//  Beat accept = in_valid && in_ready && !flush. The effective operand is
//   {in_data[31]^in_sub, in_data[30:0]}.
//  FSM:
//   - IDLE: in_ready=1.
//     On accept: acc<=effective operand, cnt<=1; next state OUT if in_last, else ACC.
//     The first beat bypasses the adder, so its bits pass through exactly.
//   - ACC: in_ready=1.
//     On accept: opb<=effective operand, last_q<=in_last, cnt<=sat(cnt+1); next state ADD.
//   - ADD: in_ready=0.
//     acc<=add_result; next state OUT if last_q, else ACC. Exactly one cycle.
//   - OUT: in_ready=0, out_valid=1, out_data=acc, out_count=cnt.
//     out_data and out_count stay stable while out_ready=0.
//     out_valid && out_ready -> IDLE next cycle. There is no bypass, so in_ready returns
//     the cycle after the handshake.
//  Timing:
//   - Throughput is one operand per 2 cycles inside a frame.
//   - Latency from the in_last accept edge to out_valid: 1 cycle for a single-beat frame,
//     2 cycles otherwise.
//  add_a and add_b are driven only from registers. They never combinationally depend on in_*.
//  Arithmetic:
//   - The block performs no FP decode, rounding or special-value handling.
//   - add_result is taken bit-exact.
//   - cnt saturates at 2^CNT_W-1. Accumulation continues after the counter saturates.
//  Boundaries:
//   - flush has priority over everything. From any state it goes to IDLE next cycle with
//     cnt=0, out_valid=0 and in_ready=0 in the flush cycle. A beat presented together
//     with flush is not accepted.
//   - in_last=1 in IDLE gives a single-beat frame.
//   - in_valid and in_sub are ignored whenever in_ready=0.
//   - rst_n low in any state (including ADD or OUT) aborts immediately. The partial frame
//     is discarded and no output is produced.
// TESTING
//  T1 {0x3F800000, 0x40000000 last}, add -> out_data=0x40400000, out_count=2,
//     out_valid 2 cycles after the last accept.
//  T2 single beat 0x40000000, in_sub=1, last -> out_data=0xC0000000, out_count=1,
//     out_valid 1 cycle later.
//  T3 {0x40000000, 0x3F000000 sub, last} with out_ready=0 for 5 cycles -> out_data=0x3FC00000
//     held stable, in_ready=0 throughout; IDLE the cycle after out_ready=1.
//  T4 CNT_W=2, five beats of 0x3F800000 -> out_data=0x40A00000, out_count=3 (saturated).
//  T5 flush in ADD cycle of a frame -> IDLE next cycle, no out_valid; the next frame
//     {0x3F800000 last} returns 0x3F800000, count 1.
//  T6 rst_n=0 while in OUT -> out_valid and out_data drop to 0 without a clock edge;
//     in_ready=1 the first cycle after release.

Source files
------------

// File: rtl/fp32_stream_accumulator.sv
// Sequential front end for an external combinational FP32 adder/subtractor.
// Accepts a framed stream of FP32 operands, accumulates them through the adder
// and emits one result plus a saturating beat count at end of frame.
module fp32_stream_accumulator #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [31:0]      in_data,
  input  logic             in_sub,
  input  logic             in_last,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [31:0]      out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      add_a,
  output logic [31:0]      add_b,
  input  logic [31:0]      add_result
);

  typedef enum logic [1:0] {StIdle, StAcc, StAdd, StOut} state_e;

  state_e           state_q, state_d;
  logic [31:0]      acc_q, acc_d;
  logic [31:0]      opb_q, opb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;
  // Holds in_ready low during reset and until the first edge after release.
  logic             rdy_q;

  logic             accept;
  logic [31:0]      eff_operand;
  logic [CNT_W-1:0] cnt_inc;

  assign eff_operand = {in_data[31] ^ in_sub, in_data[30:0]};
  assign cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  // Adder operands come straight from registers, never from the input port.
  assign add_a = acc_q;
  assign add_b = opb_q;

  // Handshake and result outputs decoded from the current state.
  always_comb begin
    in_ready  = rdy_q && !flush && ((state_q == StIdle) || (state_q == StAcc));
    accept    = in_valid && in_ready;
    out_valid = (state_q == StOut) && !flush;
    out_data  = (state_q == StOut) ? acc_q : '0;
    out_count = (state_q == StOut) ? cnt_q : '0;
  end

  // Next-state and datapath update; flush overrides every state.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          // First beat bypasses the adder so its bits pass through exactly.
          acc_d   = eff_operand;
          cnt_d   = CNT_W'(1);
          state_d = in_last ? StOut : StAcc;
        end
      end
      StAcc: begin
        if (accept) begin
          opb_d   = eff_operand;
          last_d  = in_last;
          cnt_d   = cnt_inc;
          state_d = StAdd;
        end
      end
      StAdd: begin
        acc_d   = add_result;
        state_d = last_q ? StOut : StAcc;
      end
      StOut: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (flush) begin
      state_d = StIdle;
      cnt_d   = '0;
      last_d  = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      opb_q   <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      rdy_q   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fp32_stream_accumulator.sv
// Bench for fp32_stream_accumulator: directed scenarios plus randomized frames
// checked against a real-arithmetic model of the accumulated sum.
module tb_fp32_stream_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_sub = 1'b0;
  logic        in_last = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid;
  logic [31:0] out_data, add_a, add_b, add_result;
  logic [7:0]  out_count;

  logic        in_ready2, out_valid2;
  logic [31:0] out_data2, add_a2, add_b2, add_result2;
  logic [1:0]  out_count2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // FP32 <-> real conversion for exactly representable normal values and zeros.
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == 31'd0) d = {f[31], 63'd0};
    else d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  // Behavioural external adder for each instance.
  always_comb add_result  = r2f(f2r(add_a) + f2r(add_b));
  always_comb add_result2 = r2f(f2r(add_a2) + f2r(add_b2));

  fp32_stream_accumulator #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_data(in_data), .in_sub(in_sub),
    .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_count(out_count), .out_valid(out_valid), .out_ready(out_ready), .add_a(add_a),
    .add_b(add_b), .add_result(add_result)
  );

  fp32_stream_accumulator #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_data(in_data), .in_sub(in_sub),
    .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready2), .out_data(out_data2),
    .out_count(out_count2), .out_valid(out_valid2), .out_ready(out_ready), .add_a(add_a2),
    .add_b(add_b2), .add_result(add_result2)
  );

  // Presents one beat; returns just after the accepting edge, ok=0 on timeout.
  task automatic send_beat(input logic [31:0] d, input logic sub, input logic last,
                           output bit ok);
    @(negedge clk);
    in_data = d; in_sub = sub; in_last = last; in_valid = 1'b1; ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (ok) begin @(posedge clk); #1; end
    in_valid = 1'b0; in_last = 1'b0; in_sub = 1'b0;
  endtask

  // Waits (bounded) for out_valid at successive falling edges.
  task automatic wait_out(output bit seen, output int cyc);
    seen = 1'b0; cyc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); cyc++;
      if (out_valid) begin seen = 1'b1; break; end
    end
  endtask

  task automatic take_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_tests++;
    if ({in_ready, out_valid, out_data, out_count, add_a, add_b} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: rdy=%b vld=%b data=%h cnt=%0d a=%h b=%h, required all 0",
               in_ready, out_valid, out_data, out_count, add_a, add_b);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_release_ready: got %b, required 0", in_ready);
    end
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL ready_after_reset: got %b, required 1", in_ready);
    end
  endtask

  task automatic test_add();
    bit ok, seen; int cyc;
    send_beat(32'h3F800000, 1'b0, 1'b0, ok);
    send_beat(32'h40000000, 1'b0, 1'b1, ok);
    wait_out(seen, cyc);
    n_tests++;
    if (!seen || cyc != 2) begin
      n_fail++; $display("FAIL add_latency: seen=%b cycles=%0d, required 2", seen, cyc);
    end
    n_tests++;
    if (out_data !== 32'h40400000 || out_count !== 8'd2) begin
      n_fail++;
      $display("FAIL add_result: data=%h cnt=%0d, required 40400000 cnt 2", out_data, out_count);
    end
    take_out();
  endtask

  task automatic test_single_sub();
    bit ok, seen; int cyc;
    send_beat(32'h40000000, 1'b1, 1'b1, ok);
    wait_out(seen, cyc);
    n_tests++;
    if (!seen || cyc != 1) begin
      n_fail++; $display("FAIL single_latency: seen=%b cycles=%0d, required 1", seen, cyc);
    end
    n_tests++;
    if (out_data !== 32'hC0000000 || out_count !== 8'd1) begin
      n_fail++;
      $display("FAIL single_sub: data=%h cnt=%0d, required c0000000 cnt 1", out_data, out_count);
    end
    take_out();
  endtask

  task automatic test_back_pressure();
    bit ok, seen; int cyc; int bad = 0;
    send_beat(32'h40000000, 1'b0, 1'b0, ok);
    send_beat(32'h3F000000, 1'b1, 1'b1, ok);
    wait_out(seen, cyc);
    // Junk offered while the result is held must be ignored.
    in_valid = 1'b1; in_data = 32'h447A0000; in_sub = 1'b1; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b1 || out_data !== 32'h3FC00000 || in_ready !== 1'b0) bad++;
      @(negedge clk);
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL hold_stable: %0d bad cycles, last vld=%b data=%h rdy=%b, required 0 bad",
               bad, out_valid, out_data, in_ready);
    end
    in_valid = 1'b0; in_last = 1'b0; in_sub = 1'b0;
    take_out();
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_take: rdy=%b vld=%b, required rdy 1 vld 0", in_ready, out_valid);
    end
  endtask

  task automatic test_count_saturation(input int beats);
    bit ok, seen; int cyc; real r = 0.0;
    logic [7:0] exp_cnt;
    for (int i = 0; i < beats; i++) begin
      send_beat(32'h3F800000, 1'b0, (i == beats - 1), ok);
      r += 1.0;
    end
    exp_cnt = (beats > 255) ? 8'd255 : 8'(beats);
    wait_out(seen, cyc);
    n_tests++;
    if (!seen || out_data !== r2f(r) || out_count !== exp_cnt) begin
      n_fail++;
      $display("FAIL sat_w8_%0d: data=%h cnt=%0d, required %h cnt %0d",
               beats, out_data, out_count, r2f(r), exp_cnt);
    end
    n_tests++;
    if (out_valid2 !== 1'b1 || out_data2 !== r2f(r) || out_count2 !== 2'd3) begin
      n_fail++;
      $display("FAIL sat_w2_%0d: vld=%b data=%h cnt=%0d, required %h cnt 3",
               beats, out_valid2, out_data2, out_count2, r2f(r));
    end
    take_out();
  endtask

  task automatic test_flush();
    bit ok, seen; int cyc;
    send_beat(32'h3F800000, 1'b0, 1'b0, ok);
    send_beat(32'h40000000, 1'b0, 1'b0, ok);
    @(negedge clk);
    flush = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_cycle: rdy=%b vld=%b, required 0 0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_idle: rdy=%b vld=%b, required 1 0", in_ready, out_valid);
    end
    send_beat(32'h3F800000, 1'b0, 1'b1, ok);
    wait_out(seen, cyc);
    n_tests++;
    if (!seen || cyc != 1 || out_data !== 32'h3F800000 || out_count !== 8'd1) begin
      n_fail++;
      $display("FAIL flush_next_frame: seen=%b cyc=%0d data=%h cnt=%0d, required 3f800000 cnt 1",
               seen, cyc, out_data, out_count);
    end
    take_out();
  endtask

  task automatic test_async_reset();
    bit ok, seen; int cyc;
    send_beat(32'h40400000, 1'b0, 1'b1, ok);
    wait_out(seen, cyc);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (!seen || out_valid !== 1'b0 || out_data !== 32'd0 || add_a !== 32'd0) begin
      n_fail++;
      $display("FAIL async_reset: seen=%b vld=%b data=%h a=%h, required vld 0 data 0 a 0",
               seen, out_valid, out_data, add_a);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_after_abort: rdy=%b vld=%b, required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_random_frames(input int frames);
    bit ok, seen; int cyc, n, k;
    bit neg, sub;
    logic [31:0] d, expected, first_eff;
    logic [7:0] exp_cnt;
    real r;
    for (int f = 0; f < frames; f++) begin
      n = $urandom_range(1, 7);
      r = 0.0;
      first_eff = '0;
      for (int b = 0; b < n; b++) begin
        k   = $urandom_range(1, 32);
        neg = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1));
        d   = r2f(neg ? -real'(k) : real'(k));
        if (b == 0) begin
          first_eff = {d[31] ^ sub, d[30:0]};
          r = (neg ^ sub) ? -real'(k) : real'(k);
        end else begin
          r = r + ((neg ^ sub) ? -real'(k) : real'(k));
        end
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send_beat(d, sub, (b == n - 1), ok);
        if (!ok) begin
          n_tests++; n_fail++;
          $display("FAIL rand_accept_timeout: frame %0d beat %0d", f, b);
        end
      end
      expected = (n == 1) ? first_eff : r2f(r);
      exp_cnt  = 8'(n);
      wait_out(seen, cyc);
      n_tests++;
      if (!seen || out_data !== expected || out_count !== exp_cnt) begin
        n_fail++;
        $display("FAIL rand_frame_%0d: seen=%b data=%h cnt=%0d, required %h cnt %0d",
                 f, seen, out_data, out_count, expected, exp_cnt);
      end
      n_tests++;
      if (out_count2 !== ((n > 3) ? 2'd3 : 2'(n))) begin
        n_fail++;
        $display("FAIL rand_w2_count_%0d: got %0d, required %0d",
                 f, out_count2, (n > 3) ? 3 : n);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      take_out();
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_single_sub();
    test_back_pressure();
    test_count_saturation(5);
    test_count_saturation(260);
    test_flush();
    test_async_reset();
    test_random_frames(40);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
